// File: rtl/running_light_pkg.sv
// Shared definitions for the running-light monitor: mode codes, FSM states,
// default stall threshold and LED-pattern classification helpers.
package running_light_pkg;

   typedef enum logic [1:0] {
      MODE_SHL      = 2'd0,
      MODE_SHR      = 2'd1,
      MODE_PINGPONG = 2'd2,
      MODE_BLINK    = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HUNT   = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   localparam int unsigned STALL_MAX_DEFAULT = 32'd50;
   localparam logic [3:0]  CAND_ALL          = 4'b1111;

   function automatic logic is_onehot8(input logic [7:0] y);
      return (y != 8'h00) && ((y & (y - 8'd1)) == 8'h00);
   endfunction

   // Legal running-light frames: one LED lit, all off, or all on.
   function automatic logic is_legal8(input logic [7:0] y);
      return (y == 8'h00) || (y == 8'hFF) || is_onehot8(y);
   endfunction

   function automatic logic is_onehot4(input logic [3:0] c);
      return (c != 4'd0) && ((c & (c - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] cand_index(input logic [3:0] c);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (c[i]) begin
            idx = 2'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/running_light_predict.sv
// Combinational next-frame predictor: from the last accepted frame and the
// ping-pong direction, produce the expected next frame for every mode.
module running_light_predict
   import running_light_pkg::*;
(
   input  logic [7:0]      y_last_i,
   input  logic            dir_up_i,
   output logic [3:0][7:0] pred_o
);

   // Ping-pong reverses at the end LEDs instead of wrapping.
   always_comb begin
      pred_o                = 32'h0000_0000;
      pred_o[MODE_SHL]      = {y_last_i[6:0], y_last_i[7]};
      pred_o[MODE_SHR]      = {y_last_i[0], y_last_i[7:1]};
      pred_o[MODE_BLINK]    = ~y_last_i;
      if (dir_up_i) begin
         pred_o[MODE_PINGPONG] = (y_last_i == 8'h80) ? 8'h40 : {y_last_i[6:0], 1'b0};
      end else begin
         pred_o[MODE_PINGPONG] = (y_last_i == 8'h01) ? 8'h02 : {1'b0, y_last_i[7:1]};
      end
   end

endmodule

// File: rtl/running_light_monitor.sv
// Watches an 8-LED running-light stream, identifies its mode, counts steps,
// flags sequence errors and detects a stalled pattern.
module running_light_monitor
   import running_light_pkg::*;
#(
   parameter int unsigned STALL_MAX = STALL_MAX_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  Y_in,
   output logic [1:0]  mode,
   output logic        mode_valid,
   output logic        err,
   output logic        stall,
   output logic [15:0] step_cnt
);

   localparam logic [15:0] STALL_LIMIT = 16'(STALL_MAX);

   state_e          state_q, state_d;
   logic [7:0]      y_last_q, y_last_d;
   logic [3:0]      cand_q, cand_d;
   logic            dir_up_q, dir_up_d;
   logic            pp_first_q, pp_first_d;
   logic [15:0]     idle_cnt_q, idle_cnt_d;
   logic [1:0]      mode_q, mode_d;
   logic            mode_valid_q, mode_valid_d;
   logic            err_q, err_d;
   logic            stall_q, stall_d;
   logic [15:0]     step_cnt_q, step_cnt_d;

   logic [3:0][7:0] pred_s;
   logic            change_s, legal_s, up_step_s, dn_step_s, pp_first_ok_s;
   logic [3:0]      match_s, hunt_match_s, cand_next_s;

   running_light_predict u_predict (
      .y_last_i (y_last_q),
      .dir_up_i (dir_up_q),
      .pred_o   (pred_s)
   );

   assign change_s  = (Y_in != y_last_q);
   assign legal_s   = is_legal8(Y_in);
   assign up_step_s = is_onehot8(y_last_q) && is_onehot8(Y_in) && (Y_in == {y_last_q[6:0], 1'b0});
   assign dn_step_s = is_onehot8(y_last_q) && is_onehot8(Y_in) && (Y_in == {1'b0, y_last_q[7:1]});
   // A fresh ping-pong candidate survives unless a lit LED jumped somewhere other than a neighbour.
   assign pp_first_ok_s = legal_s && is_legal8(y_last_q) &&
                          (!is_onehot8(y_last_q) || up_step_s || dn_step_s);

   always_comb begin
      for (int m = 0; m < 4; m++) begin
         match_s[m] = legal_s && (Y_in == pred_s[m]);
      end
      hunt_match_s = match_s;
      if (pp_first_q) begin
         hunt_match_s[MODE_PINGPONG] = pp_first_ok_s;
      end else begin
         hunt_match_s[MODE_PINGPONG] = match_s[MODE_PINGPONG];
      end
      cand_next_s = cand_q & hunt_match_s;
   end

   always_comb begin
      if (change_s) begin
         idle_cnt_d = 16'd0;
      end else if (idle_cnt_q == 16'hFFFF) begin
         idle_cnt_d = idle_cnt_q;
      end else begin
         idle_cnt_d = idle_cnt_q + 16'd1;
      end
      stall_d = (idle_cnt_d >= STALL_LIMIT);
   end

   always_comb begin
      state_d      = state_q;
      y_last_d     = y_last_q;
      cand_d       = cand_q;
      pp_first_d   = pp_first_q;
      mode_d       = mode_q;
      mode_valid_d = mode_valid_q;
      err_d        = 1'b0;
      step_cnt_d   = step_cnt_q;
      if ((state_q != ST_IDLE) && change_s && (up_step_s || dn_step_s)) begin
         dir_up_d = up_step_s;
      end else begin
         dir_up_d = dir_up_q;
      end

      case (state_q)
         ST_IDLE: begin
            y_last_d   = Y_in;
            cand_d     = CAND_ALL;
            pp_first_d = 1'b1;
            state_d    = ST_HUNT;
         end
         ST_HUNT: begin
            if (change_s) begin
               y_last_d   = Y_in;
               pp_first_d = 1'b0;
               if (cand_next_s == 4'd0) begin
                  err_d      = 1'b1;
                  cand_d     = CAND_ALL;
                  pp_first_d = 1'b1;
               end else if (is_onehot4(cand_next_s)) begin
                  cand_d       = cand_next_s;
                  state_d      = ST_LOCKED;
                  mode_d       = cand_index(cand_next_s);
                  mode_valid_d = 1'b1;
                  step_cnt_d   = 16'd0;
               end else begin
                  cand_d = cand_next_s;
               end
            end else begin
               cand_d = cand_q;
            end
         end
         ST_LOCKED: begin
            if (change_s) begin
               y_last_d = Y_in;
               if (match_s[mode_q]) begin
                  step_cnt_d = (step_cnt_q == 16'hFFFF) ? step_cnt_q : step_cnt_q + 16'd1;
               end else begin
                  err_d        = 1'b1;
                  mode_valid_d = 1'b0;
                  cand_d       = CAND_ALL;
                  pp_first_d   = 1'b1;
                  state_d      = ST_HUNT;
               end
            end else begin
               y_last_d = y_last_q;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            mode_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         y_last_q     <= 8'h00;
         cand_q       <= CAND_ALL;
         dir_up_q     <= 1'b1;
         pp_first_q   <= 1'b1;
         idle_cnt_q   <= 16'd0;
         mode_q       <= 2'd0;
         mode_valid_q <= 1'b0;
         err_q        <= 1'b0;
         stall_q      <= 1'b0;
         step_cnt_q   <= 16'd0;
      end else begin
         state_q      <= state_d;
         y_last_q     <= y_last_d;
         cand_q       <= cand_d;
         dir_up_q     <= dir_up_d;
         pp_first_q   <= pp_first_d;
         idle_cnt_q   <= idle_cnt_d;
         mode_q       <= mode_d;
         mode_valid_q <= mode_valid_d;
         err_q        <= err_d;
         stall_q      <= stall_d;
         step_cnt_q   <= step_cnt_d;
      end
   end

   assign mode       = mode_q;
   assign mode_valid = mode_valid_q;
   assign err        = err_q;
   assign stall      = stall_q;
   assign step_cnt   = step_cnt_q;

endmodule

// File: tb/tb_running_light_monitor.sv
// Scoreboard bench: a frame-level reference model predicts every output per
// clock; a separate monitor pops and compares after each rising edge.
module tb_running_light_monitor;

   localparam int STALL_MAX = 50;

   typedef struct packed {
      logic [1:0]  mode;
      logic        mv;
      logic        err;
      logic        stall;
      logic [15:0] steps;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [7:0]  Y_in;
   logic [1:0]  mode;
   logic        mode_valid;
   logic        err;
   logic        stall;
   logic [15:0] step_cnt;

   int   n_checks;
   int   n_errors;
   exp_t exp_q[$];
   exp_t mon_e;

   // reference model state
   int       ph;      // 0 idle, 1 hunting, 2 locked
   bit [3:0] alive;
   bit       up;
   bit       fresh;
   int       last;
   int       md;
   bit       mv;
   int       steps;
   int       quiet;

   // generator state
   int gy, act, gm, glen, gi;
   bit gup;

   running_light_monitor #(.STALL_MAX(STALL_MAX)) dut (
      .clk        (clk),
      .rst        (rst),
      .Y_in       (Y_in),
      .mode       (mode),
      .mode_valid (mode_valid),
      .err        (err),
      .stall      (stall),
      .step_cnt   (step_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int ones(input int y);
      int n;
      n = 0;
      for (int b = 0; b < 8; b++) n += (y >> b) & 1;
      return n;
   endfunction

   function automatic bit legal(input int y);
      return (ones(y) <= 1) || (y == 255);
   endfunction

   function automatic bit neighbour(input int a, input int b);
      return (ones(a) == 1) && (ones(b) == 1) && ((b == a * 2) || (a == b * 2));
   endfunction

   function automatic int successor(input int m, input int y, input bit dir_up);
      case (m)
         0: return ((y * 2) % 256) + y / 128;
         1: return y / 2 + (y % 2) * 128;
         2: begin
            if (dir_up) return (y == 128) ? 64 : (y * 2) % 256;
            return (y == 1) ? 2 : y / 2;
         end
         default: return 255 - y;
      endcase
   endfunction

   task automatic model_step(input bit r, input int y);
      bit   e, chg, ok;
      int   n, who;
      exp_t x;
      e = 1'b0;
      if (!r) begin
         ph = 0; alive = 4'hF; up = 1'b1; fresh = 1'b1; last = 0;
         md = 0; mv = 1'b0; steps = 0; quiet = 0;
      end else begin
         chg = (y != last);
         if (chg) quiet = 0;
         else if (quiet < 65535) quiet++;
         if (ph == 0) begin
            last = y; alive = 4'hF; fresh = 1'b1; ph = 1;
         end else if (chg) begin
            if (ph == 1) begin
               n = 0; who = 0;
               for (int m = 0; m < 4; m++) begin
                  if (!legal(y)) ok = 1'b0;
                  else if (m == 2 && fresh) ok = legal(last) && (ones(last) != 1 || neighbour(last, y));
                  else ok = (y == successor(m, last, up));
                  alive[m] = alive[m] && ok;
                  if (alive[m]) begin n++; who = m; end
               end
               fresh = 1'b0;
               if (n == 0) begin
                  e = 1'b1; alive = 4'hF; fresh = 1'b1;
               end else if (n == 1) begin
                  ph = 2; md = who; mv = 1'b1; steps = 0;
               end
            end else begin
               if (legal(y) && y == successor(md, last, up)) begin
                  if (steps < 65535) steps++;
               end else begin
                  e = 1'b1; mv = 1'b0; alive = 4'hF; fresh = 1'b1; ph = 1;
               end
            end
            if (neighbour(last, y)) up = (y == last * 2);
            last = y;
         end
      end
      x.mode  = md[1:0];
      x.mv    = mv;
      x.err   = e;
      x.stall = (quiet >= STALL_MAX);
      x.steps = steps[15:0];
      exp_q.push_back(x);
   endtask

   task automatic check(input string name, input logic [15:0] act_v, input logic [15:0] req_v);
      n_checks++;
      if (act_v !== req_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act_v, req_v, $time);
      end
   endtask

   task automatic drive(input bit r, input int y);
      rst  = r;
      Y_in = y[7:0];
      model_step(r, y);
      @(negedge clk);
   endtask

   task automatic hold(input int y, input int n);
      for (int k = 0; k < n; k++) drive(1'b1, y);
   endtask

   // Monitor: one expected record per rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("mode", {14'd0, mode}, {14'd0, mon_e.mode});
            check("mode_valid", {15'd0, mode_valid}, {15'd0, mon_e.mv});
            check("err", {15'd0, err}, {15'd0, mon_e.err});
            check("stall", {15'd0, stall}, {15'd0, mon_e.stall});
            check("step_cnt", step_cnt, mon_e.steps);
         end
      end
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      gy = 0; gup = 1'b1;

      drive(1'b0, 8'h01);
      drive(1'b0, 8'h01);
      check("reset_mode_valid", {15'd0, mode_valid}, 16'd0);

      // rotate-left with wrap
      for (int i = 0; i < 8; i++) hold(1 << i, 4);
      hold(8'h01, 4);
      check("shl_mode", {14'd0, mode}, 16'd0);
      check("shl_valid", {15'd0, mode_valid}, 16'd1);

      // blink
      drive(1'b0, 8'h00);
      hold(8'h00, 2);
      hold(8'hFF, 1);
      check("blink_not_yet", {15'd0, mode_valid}, 16'd0);
      hold(8'hFF, 1);
      hold(8'h00, 1);
      check("blink_mode", {14'd0, mode}, 16'd3);
      check("blink_valid", {15'd0, mode_valid}, 16'd1);

      // ping-pong
      drive(1'b0, 8'h20);
      hold(8'h20, 2); hold(8'h40, 2); hold(8'h80, 2); hold(8'h40, 1);
      check("pp_mode", {14'd0, mode}, 16'd2);
      check("pp_valid", {15'd0, mode_valid}, 16'd1);
      hold(8'h40, 1); hold(8'h20, 2); hold(8'h10, 1);
      check("pp_steps", step_cnt, 16'd2);

      // rotate-right, glitch, relock
      drive(1'b0, 8'h80);
      for (int i = 7; i >= 0; i--) hold(1 << i, 2);
      hold(8'h80, 2); hold(8'h40, 2);
      check("shr_mode", {14'd0, mode}, 16'd1);
      hold(8'h24, 1);
      check("glitch_err", {15'd0, err}, 16'd1);
      check("glitch_valid", {15'd0, mode_valid}, 16'd0);
      hold(8'h24, 1);
      check("glitch_err_pulse", {15'd0, err}, 16'd0);
      for (int i = 5; i >= 0; i--) hold(1 << i, 2);
      hold(8'h80, 2); hold(8'h40, 2);
      check("relock_valid", {15'd0, mode_valid}, 16'd1);
      check("relock_mode", {14'd0, mode}, 16'd1);

      // stall threshold and change on the threshold edge
      hold(8'h20, 1); hold(8'h20, 49);
      check("stall_49", {15'd0, stall}, 16'd0);
      hold(8'h20, 1);
      check("stall_50", {15'd0, stall}, 16'd1);
      hold(8'h10, 1);
      check("stall_clear", {15'd0, stall}, 16'd0);
      hold(8'h10, 49); hold(8'h08, 1);
      check("stall_change_wins", {15'd0, stall}, 16'd0);

      // reset while locked
      drive(1'b0, 8'h04);
      check("rst_mode", {14'd0, mode}, 16'd0);
      check("rst_valid", {15'd0, mode_valid}, 16'd0);
      check("rst_steps", step_cnt, 16'd0);
      check("rst_stall", {15'd0, stall}, 16'd0);
      hold(8'h04, 3);
      check("no_relock", {15'd0, mode_valid}, 16'd0);
      gy = 8'h04;

      // randomized streams, glitches, resets and long holds
      for (int s = 0; s < 70; s++) begin
         act = $urandom_range(0, 11);
         if (act == 0) begin
            drive(1'b0, gy);
         end else if (act == 1) begin
            gy = $urandom_range(0, 255);
            hold(gy, $urandom_range(1, 3));
         end else if (act == 2) begin
            hold(gy, $urandom_range(45, 55));
         end else begin
            gm   = $urandom_range(0, 3);
            glen = $urandom_range(3, 14);
            gup  = $urandom_range(0, 1);
            if (gm == 3) begin
               if (gy != 0 && gy != 255) gy = ($urandom_range(0, 1) != 0) ? 255 : 0;
            end else if (ones(gy) != 1) begin
               gy = 1 << $urandom_range(0, 7);
            end
            for (gi = 0; gi < glen; gi++) begin
               hold(gy, $urandom_range(1, 4));
               if (gm == 2) begin
                  if (gup && gy == 128) gup = 1'b0;
                  else if (!gup && gy == 1) gup = 1'b1;
                  gy = gup ? gy * 2 : gy / 2;
               end else begin
                  gy = successor(gm, gy, 1'b1);
               end
            end
         end
      end

      repeat (2) @(negedge clk);
      check("queue_drained", 16'(exp_q.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/running_light_monitor.md
RUNNING_LIGHT_MONITOR -- requirements
Module: running_light_monitor

Interface
REQ-001 Parameter STALL_MAX, 50: idle clocks without a pattern change before stall asserts; 1..65535.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 Y_in  input  8  LED pattern from the running-light generator, synchronous to clk.
REQ-005 mode  output  2  decoded mode: 0 rotate-left, 1 rotate-right, 2 ping-pong, 3 blink.
REQ-006 mode_valid  output  1  high while in LOCKED; mode is meaningful only then.
REQ-007 err  output  1  one-cycle pulse on a pattern sequence error.
REQ-008 stall  output  1  Y_in unchanged for at least STALL_MAX clocks.
REQ-009 step_cnt  output  16  transitions seen while LOCKED; saturates at 0xFFFF.

Function
REQ-010 y_last register holds the last accepted Y_in; a change is an edge where Y_in != y_last; y_last <= Y_in on every change.
REQ-011 Per-mode prediction from y_last: rotate-left {y[6:0],y[7]}; rotate-right {y[0],y[7:1]}; blink ~y; ping-pong: dir up -> (y==0x80 ? 0x40 : y<<1), dir down -> (y==0x01 ? 0x02 : y>>1).
REQ-012 Ping-pong dir register updates to the direction of each observed one-hot shift (up if Y_in==y_last<<1 or y_last==0x01 and Y_in==0x02 is up; down otherwise); reversal at 0x80/0x01 is the predicted case.
REQ-013 Valid patterns: one-hot, 0x00, 0xFF; any other value on a change clears all candidates.
REQ-014 States: IDLE, HUNT, LOCKED; encoding is free.
REQ-015 IDLE: first clock after reset loads y_last <= Y_in, cand[3:0] <= 4'b1111, go HUNT; no err.
REQ-016 HUNT: on a change, cand[m] cleared where Y_in != prediction(m); ping-pong dir is inferred on its first transition in HUNT and counts as consistent.
REQ-017 HUNT: if exactly one cand remains after the update -> LOCKED, mode <= that index, mode_valid <= 1, step_cnt <= 0.
REQ-018 HUNT: if no cand remains -> err pulse, cand <= 4'b1111, stay HUNT, y_last <= Y_in.
REQ-019 LOCKED: change matching prediction(mode) -> step_cnt+1 (saturating); mismatch -> err pulse, mode_valid <= 0, cand <= 4'b1111, HUNT.
REQ-020 All outputs registered; latency Y_in change -> mode_valid/err/step_cnt update = 1 clock.
REQ-021 stall counter: clear on change, else increment saturating; stall = (count >= STALL_MAX); stall never changes FSM state.
REQ-022 Change and stall threshold on the same edge: change wins, counter clears, stall deasserts next cycle.
REQ-023 mode holds its last locked value outside LOCKED.

Reset
REQ-024 rst low at a rising edge: state IDLE, mode 0, mode_valid 0, err 0, stall 0, step_cnt 0, stall counter 0, cand 4'b1111, dir up, y_last 0x00.
REQ-025 Reset mid-lock discards all history; relock restarts from IDLE.

Structure
REQ-026 Shared package running_light_pkg: mode codes MODE_SHL/SHR/PINGPONG/BLINK, FSM state encoding, STALL_MAX default; Running_Light uses the same mode codes.
REQ-027 One combinational sub-module running_light_predict (y_last, dir -> four predicted patterns); FSM, counters in the top.

Verification
REQ-028 Rotate-left stream 0x01,0x02,...,0x80,0x01 each held 4 clocks -> mode_valid=1, mode=0 after 0x80->0x01 wrap (ping-pong eliminated), err never pulses.
REQ-029 Blink stream 0x00,0xFF,0x00 -> mode=3, mode_valid=1 one clock after the second change.
REQ-030 Ping-pong 0x20,0x40,0x80,0x40 -> mode=2 after 0x80->0x40; then 0x20,0x10 -> step_cnt=2.
REQ-031 Locked rotate-right, inject 0x24 -> err one-cycle pulse, mode_valid=0 next clock, relock on resumed valid stream.
REQ-032 STALL_MAX=50, Y_in held constant -> stall=1 on 50th idle clock; change on that edge -> stall stays 0.
REQ-033 rst low for 1 clock while LOCKED -> all outputs at REQ-024 values next clock; relock needs fresh transitions.
